// File: rtl/line_blitter.sv
// rtl/line_blitter.sv - streams double-buffered line RAM columns to an 8-bit LCD bus
// Optional build macro LINE_BLITTER_BYTESWAP_EN sends the low pixel byte first.
module line_blitter #(
   parameter int HEIGHT    = 240,
   parameter int WIDTH     = 320,
   parameter int WR_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        line_done,
   output logic [8:0]  ram_raddr,
   input  logic [15:0] ram_read_data,
   output logic [7:0]  lcd_data,
   output logic        lcd_wr_n,
   output logic        lcd_dc,
   output logic        busy,
   output logic        buf_free,
   output logic        overflow,
   output logic [8:0]  col,
   output logic        frame_done
);

   localparam int IW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int PW = $clog2(2 * WR_CYCLES);

   localparam logic [IW-1:0] IDX_LAST     = IW'(HEIGHT - 1);
   localparam logic [PW-1:0] PH_LOW_END   = PW'(WR_CYCLES - 1);
   localparam logic [PW-1:0] PH_END       = PW'(2 * WR_CYCLES - 1);
   localparam logic [8:0]    COL_LAST     = 9'(WIDTH - 1);
   localparam logic [8:0]    BASE_ALT     = 9'(HEIGHT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT,
      S_HI,
      S_LO,
      S_DONE
   } state_t;

   state_t        state;
   logic [1:0]    fill;
   logic          base_sel;
   logic [IW-1:0] idx;
   logic [PW-1:0] phase;
   logic [15:0]   pixel;
   logic [8:0]    base_addr;
   logic          accept;
   logic          line_end;

`ifdef LINE_BLITTER_BYTESWAP_EN
   function automatic logic [7:0] first_byte(input logic [15:0] p);
      return p[7:0];
   endfunction
   function automatic logic [7:0] second_byte(input logic [15:0] p);
      return p[15:8];
   endfunction
`else
   function automatic logic [7:0] first_byte(input logic [15:0] p);
      return p[15:8];
   endfunction
   function automatic logic [7:0] second_byte(input logic [15:0] p);
      return p[7:0];
   endfunction
`endif

   assign base_addr = base_sel ? BASE_ALT : 9'd0;
   assign buf_free  = (fill < 2'd2);
   assign lcd_dc    = 1'b1;
   // A line_done arriving with both halves full is dropped, never queued.
   assign accept    = line_done && (fill != 2'd2);
   assign line_end  = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         fill       <= 2'd0;
         base_sel   <= 1'b0;
         idx        <= '0;
         phase      <= '0;
         pixel      <= 16'd0;
         col        <= 9'd0;
         ram_raddr  <= 9'd0;
         lcd_data   <= 8'd0;
         lcd_wr_n   <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         case ({accept, line_end})
            2'b10:   fill <= fill + 2'd1;
            2'b01:   fill <= fill - 2'd1;
            default: fill <= fill;
         endcase
         if (line_done && fill == 2'd2)
            overflow <= 1'b1;

         case (state)
            S_IDLE: begin
               if (fill != 2'd0) begin
                  state     <= S_ADDR;
                  idx       <= '0;
                  ram_raddr <= base_addr;
                  busy      <= 1'b1;
               end
            end
            S_ADDR: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               pixel    <= ram_read_data;
               lcd_data <= first_byte(ram_read_data);
               lcd_wr_n <= 1'b0;
               phase    <= '0;
               state    <= S_HI;
            end
            S_HI: begin
               if (phase == PH_LOW_END)
                  lcd_wr_n <= 1'b1;
               if (phase == PH_END) begin
                  lcd_data <= second_byte(pixel);
                  lcd_wr_n <= 1'b0;
                  phase    <= '0;
                  state    <= S_LO;
               end else begin
                  phase <= phase + PW'(1);
               end
            end
            S_LO: begin
               if (phase == PH_LOW_END)
                  lcd_wr_n <= 1'b1;
               if (phase == PH_END) begin
                  phase <= '0;
                  if (idx == IDX_LAST) begin
                     state      <= S_DONE;
                     frame_done <= (col == COL_LAST);
                  end else begin
                     idx       <= idx + IW'(1);
                     ram_raddr <= base_addr + 9'(idx) + 9'd1;
                     state     <= S_ADDR;
                  end
               end else begin
                  phase <= phase + PW'(1);
               end
            end
            S_DONE: begin
               base_sel   <= ~base_sel;
               col        <= (col == COL_LAST) ? 9'd0 : col + 9'd1;
               frame_done <= 1'b0;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_blitter.sv
// tb/tb_line_blitter.sv - scoreboard bench for line_blitter
module tb_line_blitter;

   localparam int HEIGHT = 240;
   localparam int WIDTH  = 4;
   localparam int WR     = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        line_done = 1'b0;
   logic [8:0]  ram_raddr;
   logic [15:0] ram_read_data = 16'd0;
   logic [7:0]  lcd_data;
   logic        lcd_wr_n;
   logic        lcd_dc;
   logic        busy;
   logic        buf_free;
   logic        overflow;
   logic [8:0]  col;
   logic        frame_done;

   line_blitter #(.HEIGHT(HEIGHT), .WIDTH(WIDTH), .WR_CYCLES(WR)) dut (
      .clk           (clk),
      .rst           (rst),
      .line_done     (line_done),
      .ram_raddr     (ram_raddr),
      .ram_read_data (ram_read_data),
      .lcd_data      (lcd_data),
      .lcd_wr_n      (lcd_wr_n),
      .lcd_dc        (lcd_dc),
      .busy          (busy),
      .buf_free      (buf_free),
      .overflow      (overflow),
      .col           (col),
      .frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   logic [15:0] ram [0:511];
   always @(posedge clk) ram_read_data <= ram[ram_raddr];

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [7:0] exp_q[$];
   int         f_model = 0;
   int         lines_queued = 0;
   logic       exp_overflow = 1'b0;
   int         fd_count = 0;
   logic [8:0] fd_col = 9'd0;

   task automatic push_line();
      int base;
      logic [15:0] w;
      base = (lines_queued % 2 == 1) ? HEIGHT : 0;
      for (int p = 0; p < HEIGHT; p++) begin
         w = ram[base + p];
`ifdef LINE_BLITTER_BYTESWAP_EN
         exp_q.push_back(w[7:0]);
         exp_q.push_back(w[15:8]);
`else
         exp_q.push_back(w[15:8]);
         exp_q.push_back(w[7:0]);
`endif
      end
      lines_queued++;
   endtask

   task automatic pulse();
      line_done = 1'b1;
      if (f_model == 2) begin
         exp_overflow = 1'b1;
      end else begin
         f_model++;
         push_line();
      end
      @(negedge clk);
      line_done = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      f_model = 0;
      lines_queued = 0;
      exp_overflow = 1'b0;
      fd_count = 0;
   endtask

   task automatic wait_busy(input logic lvl, input int budget);
      int n;
      n = 0;
      while (busy !== lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy !== lvl) check("wait_busy_timeout", busy, lvl);
   endtask

   // Monitor: bytes are taken on the rising edge of lcd_wr_n, as the panel latches them.
   logic       prev_wr = 1'b1;
   logic       prev_busy = 1'b0;
   int         low_cnt = 0;
   logic [7:0] low_data = 8'd0;
   logic [7:0] e;

   always @(posedge clk) begin
      #2;
      if (rst) begin
         prev_wr = 1'b1;
         prev_busy = 1'b0;
         low_cnt = 0;
         exp_q.delete();
      end else begin
         if (!lcd_wr_n) begin
            if (low_cnt == 0) low_data = lcd_data;
            low_cnt++;
         end else if (!prev_wr) begin
            check("wr_low_len", low_cnt, WR);
            check("sb_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("lcd_byte", {low_data, lcd_data}, {e, e});
            end
            low_cnt = 0;
         end
         if (prev_busy && !busy) f_model--;
         if (frame_done) begin
            fd_count++;
            fd_col = col;
         end
         prev_wr = lcd_wr_n;
         prev_busy = busy;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < 512; i++) ram[i] = 16'((i * 40503) ^ 32'h5A5A);
      ram[0] = 16'hABCD;

      do_reset();
      check("rst_busy", busy, 0);
      check("rst_wr_n", lcd_wr_n, 1);
      check("rst_dc", lcd_dc, 1);
      check("rst_buf_free", buf_free, 1);
      check("rst_overflow", overflow, 0);
      check("rst_raddr", ram_raddr, 0);
      check("rst_lcd_data", lcd_data, 0);
      check("rst_col", col, 0);
      check("rst_frame_done", frame_done, 0);

      // single line
      pulse();
      check("s1_buf_free", buf_free, 1);
      wait_busy(1'b1, 10);
      check("s1_first_addr", ram_raddr, 0);
      n = 0;
      while (busy && n < 2000) begin
         n++;
         @(negedge clk);
      end
      check("s1_busy_len", n, HEIGHT * (2 + 4 * WR) + 1);
      check("s1_buf_free_end", buf_free, 1);
      check("s1_col", col, 1);
      check("s1_sb_empty", exp_q.size(), 0);

      // double buffer
      do_reset();
      pulse();
      pulse();
      check("s2_buf_full", buf_free, 0);
      wait_busy(1'b0, 2000);
      check("s2_buf_free_after_done", buf_free, 1);
      @(negedge clk);
      check("s2_restart", busy, 1);
      check("s2_second_base", ram_raddr, HEIGHT);
      wait_busy(1'b0, 2000);
      repeat (5) @(negedge clk);
      check("s2_idle", busy, 0);
      check("s2_sb_empty", exp_q.size(), 0);

      // overflow
      do_reset();
      pulse();
      pulse();
      pulse();
      check("s3_overflow", overflow, exp_overflow);
      check("s3_buf_full", buf_free, 0);
      wait_busy(1'b0, 2000);
      check("s3_buf_free_mid", buf_free, 1);
      wait_busy(1'b1, 5);
      wait_busy(1'b0, 2000);
      repeat (10) @(negedge clk);
      check("s3_only_two", busy, 0);
      check("s3_sb_empty", exp_q.size(), 0);
      check("s3_overflow_sticky", overflow, 1);

      // line_done coinciding with DONE
      do_reset();
      pulse();
      wait_busy(1'b1, 10);
      repeat (HEIGHT * (2 + 4 * WR)) @(negedge clk);
      check("s4_in_done", busy, 1);
      pulse();
      check("s4_idle_gap", busy, 0);
      check("s4_buf_free", buf_free, 1);
      @(negedge clk);
      check("s4_restart", busy, 1);
      check("s4_base_toggle", ram_raddr, HEIGHT);
      wait_busy(1'b0, 2000);
      repeat (10) @(negedge clk);
      check("s4_f_one", busy, 0);
      check("s4_sb_empty", exp_q.size(), 0);

      // full frame
      do_reset();
      pulse();
      pulse();
      for (int k = 0; k < 4; k++) begin
         wait_busy(1'b1, 10);
         check("s5_col", col, k);
         wait_busy(1'b0, 2000);
         if (k < 2) pulse();
      end
      check("s5_col_wrap", col, 0);
      check("s5_frame_pulses", fd_count, 1);
      check("s5_frame_col", fd_col, WIDTH - 1);
      check("s5_sb_empty", exp_q.size(), 0);

      // reset during HI
      do_reset();
      pulse();
      wait_busy(1'b1, 10);
      @(negedge clk);
      @(negedge clk);
      check("s6_in_hi", lcd_wr_n, 0);
      do_reset();
      check("s6_wr_n", lcd_wr_n, 1);
      check("s6_busy", busy, 0);
      check("s6_buf_free", buf_free, 1);
      repeat (20) @(negedge clk);
      check("s6_discarded", busy, 0);
      check("s6_wr_n_idle", lcd_wr_n, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
